// File: rtl/z80_mem_ctrl_if.sv
// Bus bundle between the Z80 core, the memory controller and the synchronous memory port.
// The slave modport is the controller's view; the master modport is the CPU/memory side.
interface z80_mem_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] addr_bus;
  logic [7:0]        data_in;
  logic              MREQ_L;
  logic              RD_L;
  logic              WR_L;
  logic              RFSH_L;
  logic              WAIT_L;
  logic [7:0]        data_out;
  logic              data_oe;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;
  logic              bus_err;

  modport slave (
    input  addr_bus, data_in, MREQ_L, RD_L, WR_L, RFSH_L, mem_rdata, mem_ack,
    output WAIT_L, data_out, data_oe, mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );

  modport master (
    output addr_bus, data_in, MREQ_L, RD_L, WR_L, RFSH_L, mem_rdata, mem_ack,
    input  WAIT_L, data_out, data_oe, mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );
endinterface

// File: rtl/z80_mem_ctrl.sv
// Z80 bus-slave memory controller: turns each MREQ_L read/write cycle into one req/ack
// transaction, stalling the CPU via WAIT_L with a minimum wait count and a response timeout.
module z80_mem_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int MIN_WAIT = 1,
  parameter int TIMEOUT  = 255
) (
  input logic           clk,
  input logic           rst,
  z80_mem_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACCESS  = 3'd1;
  localparam logic [2:0] S_STRETCH = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;

  localparam logic [4:0] MIN_WAIT_C = 5'(MIN_WAIT);
  localparam logic [8:0] TIMEOUT_C  = 9'(TIMEOUT);

  logic [2:0]        state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [7:0]        to_cnt_q, to_cnt_d;
  logic              is_rd_q, is_rd_d;
  logic              wait_l_q, wait_l_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              data_oe_q, data_oe_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              bus_err_q, bus_err_d;

  logic start, illegal, oe_cond;
  logic [4:0] wait_next;

  assign start     = ~bus.MREQ_L & bus.RFSH_L & (bus.RD_L ^ bus.WR_L);
  assign illegal   = ~bus.MREQ_L & bus.RFSH_L & ~bus.RD_L & ~bus.WR_L;
  assign oe_cond   = is_rd_q & ~bus.RD_L & ~bus.MREQ_L;
  assign wait_next = {1'b0, wait_cnt_q} + 5'd1;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    to_cnt_d    = to_cnt_q;
    is_rd_d     = is_rd_q;
    wait_l_d    = wait_l_q;
    data_out_d  = data_out_q;
    data_oe_d   = data_oe_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    bus_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mem_addr_d = bus.addr_bus;
          mem_we_d   = ~bus.WR_L;
          if (!bus.WR_L) mem_wdata_d = bus.data_in;
          is_rd_d    = ~bus.RD_L;
          mem_req_d  = 1'b1;
          wait_l_d   = 1'b0;
          wait_cnt_d = 4'd0;
          to_cnt_d   = 8'd0;
          state_d    = S_ACCESS;
        end else if (illegal) begin
          is_rd_d   = 1'b0;
          bus_err_d = 1'b1;
          state_d   = S_HOLD;
        end
      end

      // WAIT_L low cycles so far is wait_cnt+1, so both exits compare against that.
      S_ACCESS: begin
        wait_cnt_d = (wait_cnt_q == 4'hF) ? wait_cnt_q : wait_cnt_q + 4'd1;
        to_cnt_d   = (to_cnt_q == 8'hFF) ? to_cnt_q : to_cnt_q + 8'd1;
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          if (is_rd_q) data_out_d = bus.mem_rdata;
          if (wait_next < MIN_WAIT_C) begin
            state_d = S_STRETCH;
          end else begin
            wait_l_d  = 1'b1;
            data_oe_d = oe_cond;
            state_d   = S_RELEASE;
          end
        end else if (({1'b0, to_cnt_q} + 9'd1) >= TIMEOUT_C) begin
          mem_req_d = 1'b0;
          if (is_rd_q) data_out_d = 8'hFF;
          bus_err_d = 1'b1;
          wait_l_d  = 1'b1;
          data_oe_d = oe_cond;
          state_d   = S_RELEASE;
        end
      end

      S_STRETCH: begin
        if (wait_next >= MIN_WAIT_C) begin
          wait_l_d  = 1'b1;
          data_oe_d = oe_cond;
          state_d   = S_RELEASE;
        end else begin
          wait_cnt_d = (wait_cnt_q == 4'hF) ? wait_cnt_q : wait_cnt_q + 4'd1;
        end
      end

      // A CPU that already dropped MREQ_L goes straight back to IDLE.
      S_RELEASE, S_HOLD: begin
        wait_l_d = 1'b1;
        if (bus.MREQ_L) begin
          data_oe_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          data_oe_d = oe_cond;
          state_d   = S_HOLD;
        end
      end

      default: begin
        state_d   = S_IDLE;
        wait_l_d  = 1'b1;
        mem_req_d = 1'b0;
        data_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= 4'd0;
      to_cnt_q    <= 8'd0;
      is_rd_q     <= 1'b0;
      wait_l_q    <= 1'b1;
      data_out_q  <= 8'h00;
      data_oe_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      to_cnt_q    <= to_cnt_d;
      is_rd_q     <= is_rd_d;
      wait_l_q    <= wait_l_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus.WAIT_L    = wait_l_q;
  assign bus.data_out  = data_out_q;
  assign bus.data_oe   = data_oe_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_z80_mem_ctrl.sv
// Testbench for z80_mem_ctrl: instance 0 has MIN_WAIT=1, instance 1 has MIN_WAIT=4, both TIMEOUT=8.
// Expected transactions go into a scoreboard queue and are popped when the DUT issues mem_req.
module tb_z80_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] addr   [2];
  logic [7:0]  din    [2];
  logic        mreq_n [2];
  logic        rd_n   [2];
  logic        wr_n   [2];
  logic        rfsh_n [2];
  logic        ack    [2];
  logic [7:0]  rdata  [2];

  logic        wait_w  [2];
  logic [7:0]  dout_w  [2];
  logic        oe_w    [2];
  logic        req_w   [2];
  logic        we_w    [2];
  logic [15:0] maddr_w [2];
  logic [7:0]  wd_w    [2];
  logic        err_w   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    z80_mem_ctrl_if #(.ADDR_W(16)) bus ();
    z80_mem_ctrl #(.ADDR_W(16), .MIN_WAIT((g == 0) ? 1 : 4), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .bus(bus)
    );
    assign bus.addr_bus  = addr[g];
    assign bus.data_in   = din[g];
    assign bus.MREQ_L    = mreq_n[g];
    assign bus.RD_L      = rd_n[g];
    assign bus.WR_L      = wr_n[g];
    assign bus.RFSH_L    = rfsh_n[g];
    assign bus.mem_ack   = ack[g];
    assign bus.mem_rdata = rdata[g];
    assign wait_w[g]  = bus.WAIT_L;
    assign dout_w[g]  = bus.data_out;
    assign oe_w[g]    = bus.data_oe;
    assign req_w[g]   = bus.mem_req;
    assign we_w[g]    = bus.mem_we;
    assign maddr_w[g] = bus.mem_addr;
    assign wd_w[g]    = bus.mem_wdata;
    assign err_w[g]   = bus.bus_err;
  end

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  dout;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int compared   = 0;
  int mismatched = 0;

  int req_cyc, wait_low, err_cnt;
  bit oe_seen, done;
  logic [15:0] o_addr;
  logic o_we;
  logic [7:0] o_wd;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_bus(input int b);
    mreq_n[b] = 1'b1; rd_n[b] = 1'b1; wr_n[b] = 1'b1; rfsh_n[b] = 1'b1; ack[b] = 1'b0;
    step();
    step();
  endtask

  // Plays the memory side: acks on the ack_after-th cycle of mem_req (0 = never) and runs until WAIT_L releases.
  task automatic run_access(input int b, input int ack_after, input logic [7:0] rd_val,
                            output int rc, output int wl, output int ec, output bit oes,
                            output logic [15:0] oa, output logic owe, output logic [7:0] owd,
                            output bit dn);
    rc = 0; wl = 0; ec = 0; oes = 0; dn = 0; oa = '0; owe = 1'b0; owd = '0;
    step();
    for (int i = 0; i < 40 && !dn; i++) begin
      ack[b] = 1'b0;
      if (err_w[b]) ec++;
      if (oe_w[b]) oes = 1;
      if (!wait_w[b]) wl++;
      if (req_w[b]) begin
        rc++;
        if (rc == 1) begin oa = maddr_w[b]; owe = we_w[b]; owd = wd_w[b]; end
        if (rc == ack_after) begin ack[b] = 1'b1; rdata[b] = rd_val; end
      end
      if (!req_w[b] && wait_w[b] && rc > 0) dn = 1;
      else step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      compared++; if (wait_w[g] !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_wait_l[%0d]: got %b expected 1", g, wait_w[g]); end
      compared++; if (dout_w[g] !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_data_out[%0d]: got %h expected 00", g, dout_w[g]); end
      compared++; if (oe_w[g] !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_data_oe[%0d]: got %b expected 0", g, oe_w[g]); end
      compared++; if (req_w[g] !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_req[%0d]: got %b expected 0", g, req_w[g]); end
      compared++; if (we_w[g] !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_we[%0d]: got %b expected 0", g, we_w[g]); end
      compared++; if (maddr_w[g] !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_mem_addr[%0d]: got %h expected 0000", g, maddr_w[g]); end
      compared++; if (wd_w[g] !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_mem_wdata[%0d]: got %h expected 00", g, wd_w[g]); end
      compared++; if (err_w[g] !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_bus_err[%0d]: got %b expected 0", g, err_w[g]); end
    end
  endtask

  task automatic test_read();
    addr[0] = 16'h1234; mreq_n[0] = 1'b0; rd_n[0] = 1'b0;
    sbq.push_back('{addr: 16'h1234, we: 1'b0, wdata: 8'h00, dout: 8'hA5});
    run_access(0, 3, 8'hA5, req_cyc, wait_low, err_cnt, oe_seen, o_addr, o_we, o_wd, done);
    e = sbq.pop_front();
    compared++; if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL read_complete: got %b expected 1", done); end
    compared++; if (o_addr !== e.addr) begin mismatched++; $display("[TB] FAIL read_mem_addr: got %h expected %h", o_addr, e.addr); end
    compared++; if (o_we !== e.we) begin mismatched++; $display("[TB] FAIL read_mem_we: got %b expected %b", o_we, e.we); end
    compared++; if (req_cyc !== 3) begin mismatched++; $display("[TB] FAIL read_req_cycles: got %0d expected 3", req_cyc); end
    compared++; if (wait_low !== 3) begin mismatched++; $display("[TB] FAIL read_wait_cycles: got %0d expected 3", wait_low); end
    compared++; if (err_cnt !== 0) begin mismatched++; $display("[TB] FAIL read_bus_err: got %0d expected 0", err_cnt); end
    compared++; if (dout_w[0] !== e.dout) begin mismatched++; $display("[TB] FAIL read_data_out: got %h expected %h", dout_w[0], e.dout); end
    compared++; if (oe_w[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL read_data_oe: got %b expected 1", oe_w[0]); end
    step();
    compared++; if (oe_w[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL read_data_oe_hold: got %b expected 1", oe_w[0]); end
    mreq_n[0] = 1'b1; rd_n[0] = 1'b1;
    step();
    compared++; if (oe_w[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL read_data_oe_off: got %b expected 0", oe_w[0]); end
    release_bus(0);
  endtask

  task automatic test_write();
    addr[1] = 16'h8001; din[1] = 8'h3C; mreq_n[1] = 1'b0; wr_n[1] = 1'b0;
    sbq.push_back('{addr: 16'h8001, we: 1'b1, wdata: 8'h3C, dout: 8'h00});
    run_access(1, 1, 8'h00, req_cyc, wait_low, err_cnt, oe_seen, o_addr, o_we, o_wd, done);
    e = sbq.pop_front();
    compared++; if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL write_complete: got %b expected 1", done); end
    compared++; if (o_addr !== e.addr) begin mismatched++; $display("[TB] FAIL write_mem_addr: got %h expected %h", o_addr, e.addr); end
    compared++; if (o_we !== e.we) begin mismatched++; $display("[TB] FAIL write_mem_we: got %b expected %b", o_we, e.we); end
    compared++; if (o_wd !== e.wdata) begin mismatched++; $display("[TB] FAIL write_mem_wdata: got %h expected %h", o_wd, e.wdata); end
    compared++; if (req_cyc !== 1) begin mismatched++; $display("[TB] FAIL write_req_cycles: got %0d expected 1", req_cyc); end
    compared++; if (wait_low !== 4) begin mismatched++; $display("[TB] FAIL write_wait_cycles: got %0d expected 4", wait_low); end
    step();
    compared++; if ((oe_seen | oe_w[1]) !== 1'b0) begin mismatched++; $display("[TB] FAIL write_data_oe: got %b expected 0", oe_seen | oe_w[1]); end
    release_bus(1);
  endtask

  task automatic test_timeout();
    addr[0] = 16'h00F0; mreq_n[0] = 1'b0; rd_n[0] = 1'b0;
    sbq.push_back('{addr: 16'h00F0, we: 1'b0, wdata: 8'h00, dout: 8'hFF});
    run_access(0, 0, 8'h00, req_cyc, wait_low, err_cnt, oe_seen, o_addr, o_we, o_wd, done);
    e = sbq.pop_front();
    compared++; if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL timeout_complete: got %b expected 1", done); end
    compared++; if (o_addr !== e.addr) begin mismatched++; $display("[TB] FAIL timeout_mem_addr: got %h expected %h", o_addr, e.addr); end
    compared++; if (req_cyc !== 8) begin mismatched++; $display("[TB] FAIL timeout_req_cycles: got %0d expected 8", req_cyc); end
    compared++; if (err_cnt !== 1) begin mismatched++; $display("[TB] FAIL timeout_bus_err: got %0d expected 1", err_cnt); end
    compared++; if (dout_w[0] !== e.dout) begin mismatched++; $display("[TB] FAIL timeout_data_out: got %h expected %h", dout_w[0], e.dout); end
    compared++; if (wait_w[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL timeout_wait_l: got %b expected 1", wait_w[0]); end
    step();
    compared++; if (err_w[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL timeout_err_single: got %b expected 0", err_w[0]); end
    release_bus(0);
  endtask

  task automatic test_refresh_illegal();
    addr[0] = 16'h0055; mreq_n[0] = 1'b0; rd_n[0] = 1'b0; rfsh_n[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      compared++; if (req_w[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL refresh_mem_req: got %b expected 0", req_w[0]); end
      compared++; if (wait_w[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL refresh_wait_l: got %b expected 1", wait_w[0]); end
    end
    rfsh_n[0] = 1'b1; wr_n[0] = 1'b0;
    step();
    compared++; if (err_w[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL illegal_bus_err: got %b expected 1", err_w[0]); end
    compared++; if (req_w[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL illegal_mem_req: got %b expected 0", req_w[0]); end
    step();
    compared++; if (err_w[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL illegal_err_single: got %b expected 0", err_w[0]); end
    compared++; if (req_w[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL illegal_mem_req_later: got %b expected 0", req_w[0]); end
    release_bus(0);
  endtask

  task automatic test_back_to_back();
    int total_req;
    total_req = 0;
    sbq.push_back('{addr: 16'h0000, we: 1'b0, wdata: 8'h00, dout: 8'h11});
    sbq.push_back('{addr: 16'h0001, we: 1'b0, wdata: 8'h00, dout: 8'h22});
    for (int k = 0; k < 2; k++) begin
      addr[0] = 16'(k); mreq_n[0] = 1'b0; rd_n[0] = 1'b0;
      run_access(0, 2 - k, (k == 0) ? 8'h11 : 8'h22, req_cyc, wait_low, err_cnt, oe_seen, o_addr, o_we, o_wd, done);
      e = sbq.pop_front();
      total_req += (req_cyc > 0) ? 1 : 0;
      compared++; if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_complete[%0d]: got %b expected 1", k, done); end
      compared++; if (o_addr !== e.addr) begin mismatched++; $display("[TB] FAIL b2b_mem_addr[%0d]: got %h expected %h", k, o_addr, e.addr); end
      compared++; if (dout_w[0] !== e.dout) begin mismatched++; $display("[TB] FAIL b2b_data_out[%0d]: got %h expected %h", k, dout_w[0], e.dout); end
      compared++; if (oe_w[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_data_oe[%0d]: got %b expected 1", k, oe_w[0]); end
      mreq_n[0] = 1'b1; rd_n[0] = 1'b1;
      step();
      compared++; if (oe_w[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_data_oe_gap[%0d]: got %b expected 0", k, oe_w[0]); end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (req_w[0]) total_req++;
    end
    compared++; if (total_req !== 2) begin mismatched++; $display("[TB] FAIL b2b_transactions: got %0d expected 2", total_req); end
    release_bus(0);
  endtask

  task automatic test_reset_mid_access();
    addr[0] = 16'h4321; mreq_n[0] = 1'b0; rd_n[0] = 1'b0;
    step();
    compared++; if (req_w[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL rstmid_req_started: got %b expected 1", req_w[0]); end
    step();
    rst = 1'b1;
    step();
    compared++; if (req_w[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_mem_req: got %b expected 0", req_w[0]); end
    compared++; if (wait_w[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL rstmid_wait_l: got %b expected 1", wait_w[0]); end
    compared++; if (dout_w[0] !== 8'h00) begin mismatched++; $display("[TB] FAIL rstmid_data_out: got %h expected 00", dout_w[0]); end
    compared++; if (maddr_w[0] !== 16'h0000) begin mismatched++; $display("[TB] FAIL rstmid_mem_addr: got %h expected 0000", maddr_w[0]); end
    compared++; if (oe_w[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_data_oe: got %b expected 0", oe_w[0]); end
    rst = 1'b0; mreq_n[0] = 1'b1; rd_n[0] = 1'b1; ack[0] = 1'b1; rdata[0] = 8'h5A;
    step();
    ack[0] = 1'b0;
    step();
    compared++; if (req_w[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL late_ack_mem_req: got %b expected 0", req_w[0]); end
    compared++; if (dout_w[0] !== 8'h00) begin mismatched++; $display("[TB] FAIL late_ack_data_out: got %h expected 00", dout_w[0]); end
    compared++; if (wait_w[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL late_ack_wait_l: got %b expected 1", wait_w[0]); end
  endtask

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      addr[g] = '0; din[g] = '0; mreq_n[g] = 1'b1; rd_n[g] = 1'b1; wr_n[g] = 1'b1;
      rfsh_n[g] = 1'b1; ack[g] = 1'b0; rdata[g] = '0;
    end
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_refresh_illegal();
    test_back_to_back();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/z80_mem_ctrl.md
Name: z80_mem_ctrl

Overview:
Bus-slave memory controller directly downstream of the z80 core. It consumes the core's MREQ_L/RD_L/WR_L/RFSH_L bus cycles and turns each one into a single req/ack transaction on a synchronous memory port. For reads it drives the data bus; it stalls the CPU through WAIT_L until the memory responds. It also enforces a minimum wait-state count and a response timeout.

Parameters:
ADDR_W, 16, width of addr_bus and mem_addr
MIN_WAIT, 1, minimum cycles WAIT_L is held low per access (range 1..15)
TIMEOUT, 255, cycles without mem_ack before the access is aborted (range 1..255)

Ports:
clk  in  1  system clock; all bus inputs are synchronous to it
rst  in  1  synchronous reset, active-high
addr_bus  in  ADDR_W  CPU address
data_in  in  8  CPU data bus (write data)
MREQ_L  in  1  memory request, active-low
RD_L  in  1  read strobe, active-low
WR_L  in  1  write strobe, active-low
RFSH_L  in  1  refresh cycle, active-low; refresh cycles are ignored
WAIT_L  out  1  CPU stall, active-low
data_out  out  8  read data to CPU
data_oe  out  1  data_out valid and driven onto the bus
mem_req  out  1  memory request, level
mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
mem_addr  out  ADDR_W  latched address
mem_wdata  out  8  latched write data
mem_rdata  in  8  memory read data; valid when mem_ack=1
mem_ack  in  1  single-cycle acknowledge
bus_err  out  1  one-cycle pulse on timeout or illegal strobe combination

Behaviour:
- Reset values (all registered outputs): WAIT_L=1, data_out=8'h00, data_oe=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, bus_err=0; state=IDLE, counters=0.
- rst takes effect mid-transaction on the next edge: mem_req drops, WAIT_L=1. A late mem_ack after reset is ignored.
- States:
  - IDLE: start when MREQ_L=0, RFSH_L=1, and exactly one of RD_L/WR_L is 0.
    - On start, latch addr_bus into mem_addr, data_in into mem_wdata (write only), and ~WR_L into mem_we.
    - Set mem_req=1 and WAIT_L=0; go to ACCESS.
    - MREQ_L=0 with both RD_L=0 and WR_L=0: no access, bus_err pulse, go to HOLD.
    - RFSH_L=0 cycles: no action.
  - ACCESS: mem_req held at 1 until mem_ack is sampled 1.
    - wait_cnt increments every cycle in ACCESS.
    - On mem_ack: mem_req=0 on the next edge. For a read, capture mem_rdata into data_out.
    - Then go to STRETCH if wait_cnt+1 < MIN_WAIT, else go to RELEASE.
    - to_cnt reaching TIMEOUT with no ack: mem_req=0, data_out=8'hFF (reads), bus_err pulse, go to RELEASE.
  - STRETCH: WAIT_L stays 0 until wait_cnt reaches MIN_WAIT, then go to RELEASE.
  - RELEASE: WAIT_L=1. data_oe=1 if and only if the access is a read and RD_L=0 and MREQ_L=0. Go to HOLD.
  - HOLD: keep data_oe under the same condition as RELEASE. Go to IDLE when MREQ_L=1; data_oe=0 in that same edge.
- Latency: start cycle N gives WAIT_L=0 and mem_req=1 visible at N+1. An ack at cycle M gives WAIT_L=1 at M+1 if MIN_WAIT is already satisfied.
- WAIT_L is never 0 outside ACCESS/STRETCH.
- mem_addr, mem_we and mem_wdata are stable for the entire time mem_req=1.
- Exactly one mem_req rising edge per CPU access; a new access is accepted only after MREQ_L has returned to 1.
- MREQ_L rising in ACCESS (CPU protocol violation): the transaction still completes to ack or timeout, then passes through RELEASE to IDLE.
- mem_ack in IDLE/STRETCH/RELEASE/HOLD is ignored.
- Counters saturate and never wrap: wait_cnt is 4 bits, to_cnt is 8 bits. Both clear on start.

Test Plan:
- Read: addr=16'h1234, MREQ_L=RD_L=0; memory acks 3 cycles after req with rdata=8'hA5. Required: mem_req high 3 cycles, mem_we=0, mem_addr=16'h1234, WAIT_L low 3 cycles, then data_out=8'hA5 with data_oe=1 until MREQ_L=1.
- Write: addr=16'h8001, data_in=8'h3C, WR_L=0; ack after 1 cycle with MIN_WAIT=4. Required: mem_we=1, mem_wdata=8'h3C, WAIT_L low exactly 4 cycles, data_oe never 1.
- Timeout: TIMEOUT=8, read with no ack. Required: mem_req drops after 8 cycles, bus_err single pulse, data_out=8'hFF, WAIT_L returns to 1.
- Refresh/illegal: MREQ_L=0 with RFSH_L=0 gives no mem_req. RD_L=WR_L=0 gives a bus_err pulse and no mem_req.
- Back-to-back reads 16'h0000 then 16'h0001, with MREQ_L high for 1 cycle between them. Required: exactly two req/ack transactions with the correct addresses; data_oe deasserts between them.
- Reset mid-ACCESS: assert rst while mem_req=1. Required: next cycle mem_req=0, WAIT_L=1, all outputs at reset values; a subsequent ack is ignored.
